// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for 7-segment display logic:
//   - SEG_A..SEG_G : bit positions of each segment in a 7-bit segment word
//   - HEX_SEG_TABLE: 16-entry hex-to-segment table, active-high, gfedcba
//   - POL_*        : polarity selector constants
//   - seg_apply_pol: maps an active-high segment word onto pin polarity
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Entry [n] is the active-high gfedcba pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

    localparam logic POL_ACTIVE_HIGH = 1'b0;
    localparam logic POL_ACTIVE_LOW  = 1'b1;

    // Convert an active-high segment word to the pin level for the polarity.
    function automatic logic [6:0] seg_apply_pol(input logic [6:0] seg_hi,
                                                 input logic       active_low);
        return active_low ? ~seg_hi : seg_hi;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex nibble to 7-segment decoder (active-high).
//   i_nibble : 4-bit hex digit
//   o_seg    : segments, bit0=a .. bit6=g, 1 = lit
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Table lookup of the segment pattern for the nibble.
    always_comb begin
        o_seg = HEX_SEG_TABLE[i_nibble];
    end

endmodule

// File: rtl/display7s_scan.sv
// -----------------------------------------------------------------------------
// display7s_scan
// Time-multiplexed driver for an N-digit common-anode 7-segment bank with
// double-buffered value/dp, per-slot anti-ghost blanking, leading-zero
// suppression and selectable pin polarity. All pins are registered.
//   clk, rst    : clock, asynchronous active-high reset
//   enable      : 1 = scanning, 0 = dark with scan halted
//   load        : strobe capturing value/dp into the shadow buffer
//   value, dp   : packed hex nibbles and decimal points, digit 0 = LSB
//   blank_lz    : 1 = suppress leading zeros
//   seg, dp_out : segment and decimal-point pins
//   an          : digit select pins
//   frame_done  : one-cycle pulse after the last digit's slot ends
// -----------------------------------------------------------------------------
module display7s_scan
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [DIG_W-1:0]    DIG_LAST  = DIG_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]          SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic                DP_OFF    = SEG_ACTIVE_LOW;

    logic [CNT_W-1:0]      r_cnt;
    logic [DIG_W-1:0]      r_dig;
    logic [4*N_DIGITS-1:0] r_shadow_val;
    logic [N_DIGITS-1:0]   r_shadow_dp;
    logic                  r_pending;
    logic [4*N_DIGITS-1:0] r_active_val;
    logic [N_DIGITS-1:0]   r_active_dp;

    logic                  w_boundary;
    logic                  w_on;
    logic [N_DIGITS-1:0]   w_sup;
    logic                  w_run;
    logic [3:0]            w_nibble;
    logic                  w_dig_dp;
    logic                  w_dig_sup;
    logic [N_DIGITS-1:0]   w_an_sel;
    logic [6:0]            w_seg_hi;

    assign w_boundary = enable && (r_cnt == CNT_LAST) && (r_dig == DIG_LAST);
    assign w_on       = enable && (r_cnt >= CNT_BLANK);

    // Slot counter and digit index; disabling parks cnt at 0 and holds dig.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_dig <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_dig <= (r_dig == DIG_LAST) ? DIG_W'(0) : r_dig + DIG_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Shadow/active double buffer; active only changes at a frame boundary.
    // A load on the boundary cycle bypasses the shadow and never sets pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_pending    <= 1'b0;
            r_active_val <= '0;
            r_active_dp  <= '0;
        end else begin
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp;
            end
            if (w_boundary) begin
                if (load) begin
                    r_active_val <= value;
                    r_active_dp  <= dp;
                end else if (r_pending) begin
                    r_active_val <= r_shadow_val;
                    r_active_dp  <= r_shadow_dp;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while nibble and dp
    // are both zero; digit 0 is never included.
    always_comb begin
        w_sup = '0;
        w_run = blank_lz;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (w_run && (r_active_val[i*4 +: 4] == 4'h0) && !r_active_dp[i]) begin
                w_sup[i] = 1'b1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    // Select nibble, dp, suppression bit and one-hot anode for the current digit.
    always_comb begin
        w_nibble  = 4'h0;
        w_dig_dp  = 1'b0;
        w_dig_sup = 1'b0;
        w_an_sel  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_dig == DIG_W'(i)) begin
                w_nibble    = r_active_val[i*4 +: 4];
                w_dig_dp    = r_active_dp[i];
                w_dig_sup   = w_sup[i];
                w_an_sel[i] = 1'b1;
            end else begin
                w_an_sel[i] = 1'b0;
            end
        end
    end

    seg7_hex_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_hi)
    );

    // Pin registers: one cycle behind the counter state, dark during BLANK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp_out     <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            if (w_on) begin
                an     <= w_an_sel ^ AN_OFF;
                seg    <= w_dig_sup ? SEG_OFF : seg_apply_pol(w_seg_hi, SEG_ACTIVE_LOW);
                dp_out <= w_dig_dp ^ DP_OFF;
            end else begin
                an     <= AN_OFF;
                seg    <= SEG_OFF;
                dp_out <= DP_OFF;
            end
            frame_done <= w_boundary;
        end
    end

endmodule
